// File: rtl/clk_stimulus.sv
// Simulation-only clock/reset stimulus: stepped-period free-running clocks and stepped-hold power-on resets.
// Optional macro CLK_STIM_SYNC_RELEASE_EN makes each reset release on a rising edge of clkv[j % CLOCKS].
`timescale 1ns/10ps

module clk_stimulus #(
  parameter int CLOCKS     = 2,
  parameter int CLOCK_BASE = 1000000,
  parameter int CLOCK_INC  = 1000,
  parameter int RESETS     = 2,
  parameter int RESET_BASE = 2000,
  parameter int RESET_INC  = 100
) (
  output logic [CLOCKS-1:0] clkv,
  output logic [RESETS-1:0] rstnv,
  output logic [RESETS-1:0] rstv
);

  initial begin
    if (CLOCKS < 1) $fatal(1, "clk_stimulus: CLOCKS must be at least 1 (got %0d)", CLOCKS);
    if (RESETS < 1) $fatal(1, "clk_stimulus: RESETS must be at least 1 (got %0d)", RESETS);
  end

  for (genvar gi = 0; gi < CLOCKS; gi++) begin : g_clk
    localparam longint PERIOD_PS = longint'(CLOCK_BASE) + longint'(gi) * longint'(CLOCK_INC);

    logic   clk_q = 1'b0;
    longint edge_cnt;
    real    wait_ns;

    // Each delay is taken from the absolute time of the next edge, so rounding never accumulates.
    initial begin
      if (PERIOD_PS < 2) $fatal(1, "clk_stimulus: clock %0d period %0d ps is below 2 ps", gi, PERIOD_PS);
      $display("clk_stimulus: clock %0d period %0d ps freq %f MHz", gi, PERIOD_PS,
               1.0e6 / real'(PERIOD_PS));
      edge_cnt = 0;
      forever begin
        edge_cnt = edge_cnt + 1;
        wait_ns  = (real'(edge_cnt * PERIOD_PS) / 2000.0) - $realtime;
        if (wait_ns < 0.0) wait_ns = 0.0;
        #(wait_ns);
        clk_q = ~clk_q;
      end
    end

    assign clkv[gi] = clk_q;
  end

  for (genvar gj = 0; gj < RESETS; gj++) begin : g_rst
    localparam longint HOLD_NS = longint'(RESET_BASE) + longint'(gj) * longint'(RESET_INC);

    logic rstn_q = 1'b0;

    initial begin
      $display("clk_stimulus: reset %0d hold %0d ns", gj, HOLD_NS);
    end

`ifdef CLK_STIM_SYNC_RELEASE_EN
    localparam int REF_CLK = gj % CLOCKS;

    // Comparing against time (not an armed flag) keeps an edge landing exactly on the hold time race-free.
    always @(posedge clkv[REF_CLK]) begin
      if ($realtime >= real'(HOLD_NS) - 0.001) rstn_q <= 1'b1;
    end
`else
    initial begin
      #(HOLD_NS);
      rstn_q = 1'b1;
    end
`endif

    assign rstnv[gj] = rstn_q;
    assign rstv[gj]  = ~rstn_q;
  end

endmodule

// File: tb/tb_clk_stimulus.sv
// Self-checking bench for clk_stimulus: edge-time table, randomized sampling against a timing model, post-run edge analysis.
// Build with CLK_STIM_SYNC_RELEASE_EN defined to check the clock-synchronous reset release.
`timescale 1ns/10ps

module tb_clk_stimulus;

  logic [1:0] clkv;
  logic [1:0] rstnv;
  logic [1:0] rstv;
  logic [0:0] sclkv;
  logic [2:0] srstnv;
  logic [2:0] srstv;

  int testsRun    = 0;
  int testsFailed = 0;

  clk_stimulus #(
    .CLOCKS(2), .CLOCK_BASE(1000000), .CLOCK_INC(1000),
    .RESETS(2), .RESET_BASE(2000), .RESET_INC(100)
  ) dut (
    .clkv(clkv), .rstnv(rstnv), .rstv(rstv)
  );

  clk_stimulus #(
    .CLOCKS(1), .CLOCK_BASE(10000), .CLOCK_INC(1000),
    .RESETS(3), .RESET_BASE(2000), .RESET_INC(100)
  ) dutSmall (
    .clkv(sclkv), .rstnv(srstnv), .rstv(srstv)
  );

  // Edge-time logs gathered while the run proceeds and analysed at the end.
  real rise0[$], fall0[$], rise1[$], fall1[$];
  real rstnRise0[$], rstnRise1[$], rstvFall0[$], rstvFall1[$];
  real sRise[$], sRstnRise0[$], sRstnRise1[$], sRstnRise2[$];
  int  rstnRefalls = 0;

  always @(posedge clkv[0]) rise0.push_back($realtime);
  always @(negedge clkv[0]) if ($realtime > 0.0) fall0.push_back($realtime);
  always @(posedge clkv[1]) rise1.push_back($realtime);
  always @(negedge clkv[1]) if ($realtime > 0.0) fall1.push_back($realtime);
  always @(posedge rstnv[0]) rstnRise0.push_back($realtime);
  always @(posedge rstnv[1]) rstnRise1.push_back($realtime);
  always @(negedge rstv[0]) if ($realtime > 0.0) rstvFall0.push_back($realtime);
  always @(negedge rstv[1]) if ($realtime > 0.0) rstvFall1.push_back($realtime);
  always @(negedge rstnv[0]) if ($realtime > 0.0) rstnRefalls++;
  always @(negedge rstnv[1]) if ($realtime > 0.0) rstnRefalls++;
  always @(negedge srstnv[0]) if ($realtime > 0.0) rstnRefalls++;
  always @(posedge sclkv[0]) if (sRise.size() < 4) sRise.push_back($realtime);
  always @(posedge srstnv[0]) sRstnRise0.push_back($realtime);
  always @(posedge srstnv[1]) sRstnRise1.push_back($realtime);
  always @(posedge srstnv[2]) sRstnRise2.push_back($realtime);

  typedef struct {
    real        t;
    logic [1:0] clk;
    logic [1:0] rstn;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic checkTime(input string name, input real actual, input real expected);
    testsRun++;
    if (actual > expected + 0.001 || actual < expected - 0.001) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %f ns expected %f ns", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input real t);
    if (t > $realtime) #(t - $realtime);
  endtask

  function automatic real qAt(input real q[$], input int i);
    return (i < q.size()) ? q[i] : -1.0;
  endfunction

  // Clock level at time tPs: level toggles every half period starting low.
  function automatic logic clkModel(input longint periodPs, input longint tPs);
    return ((tPs / (periodPs / 2)) % 2) == 1;
  endfunction

  function automatic longint releasePs(input longint holdNs, input longint refPeriodPs);
    longint holdPs;
    longint halfPs;
    longint m;
    holdPs = holdNs * 1000;
    halfPs = refPeriodPs / 2;
`ifdef CLK_STIM_SYNC_RELEASE_EN
    // Rising edges sit at odd multiples of the half period; take the first one not before the hold time.
    m = (holdPs + halfPs - 1) / halfPs;
    if (m % 2 == 0) m = m + 1;
    return m * halfPs;
`else
    m = halfPs;
    return holdPs + 0 * m;
`endif
  endfunction

  function automatic logic rstnModel(input longint holdNs, input longint refPeriodPs, input longint tPs);
    return tPs >= releasePs(holdNs, refPeriodPs);
  endfunction

  task automatic tableTest();
    logic [1:0] relDef [12];
    logic [1:0] relSync[12];
    real        times  [12] = '{0.25, 500.25, 500.75, 1000.25, 1001.25, 1999.75,
                                2000.25, 2099.75, 2100.25, 2500.25, 2502.25, 2502.75};
    logic [1:0] clks   [12] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11,
                                2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    relDef  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    relSync = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.t   = times[i];
      v.clk = clks[i];
`ifdef CLK_STIM_SYNC_RELEASE_EN
      v.rstn = relSync[i];
`else
      v.rstn = relDef[i];
`endif
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].t);
      checkOutput($sformatf("vec%0d", i), {10'd0, rstv, rstnv, clkv},
                  {10'd0, ~vecs[i].rstn, vecs[i].rstn, vecs[i].clk});
    end
  endtask

  task automatic randomTest();
    longint     tNs = 0;
    longint     tPs;
    logic [1:0] eClk, eRstn;
    logic [2:0] eSRstn;
    logic       eSClk;
    for (int n = 0; n < 48; n++) begin
      tNs = tNs + ((n < 10) ? longint'($urandom_range(1, 500)) : longint'($urandom_range(1, 40000)));
      if (tNs >= 1000000) break;
      applyStimulus(real'(tNs) + 0.25);
      tPs    = tNs * 1000 + 250;
      eClk   = {clkModel(1001000, tPs), clkModel(1000000, tPs)};
      eRstn  = {rstnModel(2100, 1001000, tPs), rstnModel(2000, 1000000, tPs)};
      eSClk  = clkModel(10000, tPs);
      eSRstn = {rstnModel(2200, 10000, tPs), rstnModel(2100, 10000, tPs), rstnModel(2000, 10000, tPs)};
      checkOutput($sformatf("rand%0d@%0dns", n, tNs),
                  {3'd0, srstv, srstnv, sclkv, rstv, rstnv, clkv},
                  {3'd0, ~eSRstn, eSRstn, eSClk, ~eRstn, eRstn, eClk});
    end
  endtask

  initial begin
    real expR0, expR1, expS0, expS1, expS2;
`ifdef CLK_STIM_SYNC_RELEASE_EN
    expR0 = 2500.0; expR1 = 2502.5; expS0 = 2005.0; expS1 = 2105.0; expS2 = 2205.0;
`else
    expR0 = 2000.0; expR1 = 2100.0; expS0 = 2000.0; expS1 = 2100.0; expS2 = 2200.0;
`endif
    fork
      tableTest();
      randomTest();
    join
    applyStimulus(1001100.0);

    checkTime("clk0_first_rise", qAt(rise0, 0), 500.0);
    checkTime("clk0_first_fall", qAt(fall0, 0), 1000.0);
    checkTime("clk0_period_100", (qAt(rise0, 100) - qAt(rise0, 0)) / 100.0, 1000.0);
    checkTime("clk1_first_rise", qAt(rise1, 0), 500.5);
    checkTime("clk1_period_100", (qAt(rise1, 100) - qAt(rise1, 0)) / 100.0, 1001.0);
    checkTime("clk0_fall_1000", qAt(fall0, 999), 1000000.0);
    checkTime("clk1_lag_1000", qAt(fall1, 999) - qAt(fall0, 999), 1000.0);
    checkTime("rstn0_release", qAt(rstnRise0, 0), expR0);
    checkTime("rstn1_release", qAt(rstnRise1, 0), expR1);
    checkTime("rstv0_release", qAt(rstvFall0, 0), expR0);
    checkTime("rstv1_release", qAt(rstvFall1, 0), expR1);
    checkOutput("release_count", 16'(rstnRise0.size() + rstnRise1.size() + rstnRefalls), 16'd2);
    checkTime("small_first_rise", qAt(sRise, 0), 5.0);
    checkTime("small_period", qAt(sRise, 1) - qAt(sRise, 0), 10.0);
    checkTime("small_rstn0", qAt(sRstnRise0, 0), expS0);
    checkTime("small_rstn1", qAt(sRstnRise1, 0), expS1);
    checkTime("small_rstn2", qAt(sRstnRise2, 0), expS2);
    checkOutput("final_levels", {10'd0, srstnv, srstv[0], rstnv, rstv}, {10'd0, 3'b111, 1'b0, 2'b11, 2'b00});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
